wishbone_slave_mc: RTL and testbench

WISHBONE_SLAVE_MC -- requirements
Module: wishbone_slave_mc

---
 rtl/wishbone_slave_mc.sv | 132 +++++++++++++
 tb/tb_wishbone_slave_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wishbone_slave_mc.sv
// rtl/wishbone_slave_mc.sv - Wishbone slave bridging to a register file and FIFO channels.
// Optional FIFO wait timeout enabled by defining WB_SLAVE_MC_TIMEOUT_EN.
module wishbone_slave_mc #(
  parameter int               DATA_W    = 128,
  parameter int               ADR_W     = 5,
  parameter int               FIFO_CH   = 2,
  parameter int               REG_LIMIT = 16,
  parameter logic [ADR_W-1:0] CMD_ADR   = ADR_W'(3),
  parameter int               TIMEOUT   = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               strobe,
  input  logic               we_i,
  input  logic [ADR_W-1:0]   adr_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic               ack_o,
  output logic               error_o,
  output logic [ADR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]  host_data_o,
  input  logic [DATA_W-1:0]  host_data_i,
  output logic               reg_read_en,
  output logic               reg_write_en,
  output logic [FIFO_CH-1:0] fifo_read_en,
  output logic [FIFO_CH-1:0] fifo_write_en,
  input  logic [FIFO_CH-1:0] fifo_read_wait,
  input  logic [FIFO_CH-1:0] fifo_write_wait,
  output logic               new_command
);

  localparam int CH_W = (FIFO_CH > 1) ? $clog2(FIFO_CH) : 1;

  if ((FIFO_CH < 1) || (FIFO_CH > 8) || (TIMEOUT < 1)) begin : g_param_check
    $error("wishbone_slave_mc: FIFO_CH must be 1..8 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACCESS, S_ACK, S_ERR, S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [ADR_W-1:0]    adr_q;
  logic [DATA_W-1:0]   host_data_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                we_q;
  logic                is_reg_q;
  logic [CH_W-1:0]     chan_q;

  logic                is_reg_in, is_fifo_in, sel_wait;
  logic [CH_W-1:0]     chan_d;

  assign is_reg_in  = int'(adr_i) < REG_LIMIT;
  assign is_fifo_in = (int'(adr_i) >= REG_LIMIT) && (int'(adr_i) < REG_LIMIT + FIFO_CH);
  assign chan_d     = CH_W'(int'(adr_i) - REG_LIMIT);
  assign sel_wait   = we_q ? fifo_write_wait[chan_q] : fifo_read_wait[chan_q];

`ifdef WB_SLAVE_MC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] cnt_q;
  logic            timed_out;

  // Cleared while idle so every entry into WAIT starts from zero.
  always_ff @(posedge clock) begin
    if (reset)                           cnt_q <= '0;
    else if (state_q == S_IDLE)          cnt_q <= '0;
    else if (state_q == S_WAIT && sel_wait) cnt_q <= cnt_q + TO_W'(1);
  end

  assign timed_out = (cnt_q == TO_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (is_reg_in)       state_d = S_ACCESS;
          else if (is_fifo_in) state_d = S_WAIT;
          else                 state_d = S_ERR;
        end
      end
      S_WAIT: begin
        if (!sel_wait)       state_d = S_ACCESS;
`ifdef WB_SLAVE_MC_TIMEOUT_EN
        else if (timed_out)  state_d = S_ERR;
`endif
      end
      S_ACCESS:     state_d = S_ACK;
      S_ACK, S_ERR: state_d = S_RELEASE;
      S_RELEASE:    if (!strobe) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      host_data_q <= '0;
      wb_data_q   <= '0;
      we_q        <= 1'b0;
      is_reg_q    <= 1'b0;
      chan_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && strobe) begin
        adr_q       <= adr_i;
        host_data_q <= wb_data_i;
        we_q        <= we_i;
        is_reg_q    <= is_reg_in;
        chan_q      <= chan_d;
      end
      if (state_q == S_ACCESS && !we_q) wb_data_q <= host_data_i;
    end
  end

  logic in_access;
  assign in_access = (state_q == S_ACCESS);

  assign adr_o         = adr_q;
  assign host_data_o   = host_data_q;
  assign wb_data_o     = wb_data_q;
  assign ack_o         = (state_q == S_ACK);
  assign error_o       = (state_q == S_ERR);
  assign reg_read_en   = in_access &&  is_reg_q && !we_q;
  assign reg_write_en  = in_access &&  is_reg_q &&  we_q;
  assign fifo_read_en  = (in_access && !is_reg_q && !we_q) ? (FIFO_CH'(1) << chan_q) : '0;
  assign fifo_write_en = (in_access && !is_reg_q &&  we_q) ? (FIFO_CH'(1) << chan_q) : '0;
  assign new_command   = reg_write_en && (adr_q == CMD_ADR);

endmodule

// File: tb/tb_wishbone_slave_mc.sv
// tb/tb_wishbone_slave_mc.sv - Scoreboard bench for wishbone_slave_mc.
module tb_wishbone_slave_mc;

  logic         clock = 1'b0;
  logic         reset, strobe, we_i;
  logic [4:0]   adr_i, adr_o;
  logic [127:0] wb_data_i, wb_data_o, host_data_o, host_data_i;
  logic         ack_o, error_o, reg_read_en, reg_write_en, new_command;
  logic [1:0]   fifo_read_en, fifo_write_en, fifo_read_wait, fifo_write_wait;

  int checks = 0;
  int errors = 0;

  typedef struct { logic err; logic [127:0] data; } exp_t;
  exp_t         exp_q[$];
  logic [127:0] last_rd = '0;

  always #5 clock = ~clock;

  wishbone_slave_mc #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .strobe(strobe), .we_i(we_i), .adr_i(adr_i),
    .wb_data_i(wb_data_i), .wb_data_o(wb_data_o), .ack_o(ack_o), .error_o(error_o),
    .adr_o(adr_o), .host_data_o(host_data_o), .host_data_i(host_data_i),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
    .fifo_read_en(fifo_read_en), .fifo_write_en(fifo_write_en),
    .fifo_read_wait(fifo_read_wait), .fifo_write_wait(fifo_write_wait),
    .new_command(new_command)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops one expectation for every ack/error the DUT presents.
  always @(negedge clock) begin
    exp_t e;
    checks++;
    if ((ack_o && error_o) ||
        ($countones({reg_read_en, reg_write_en, fifo_read_en, fifo_write_en}) > 1)) begin
      errors++;
      $display("FAIL invariant: ack=%0b err=%0b en=%b", ack_o, error_o,
               {reg_read_en, reg_write_en, fifo_read_en, fifo_write_en});
    end
    if (ack_o || error_o) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", ack_o, error_o);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind_err", {127'b0, error_o}, {127'b0, e.err});
        check("wb_data_o", wb_data_o, e.data);
      end
    end
  end

  task automatic xfer(input logic we, input logic [4:0] adr, input logic [127:0] d,
                      input logic [127:0] hd, input int n_wait, input int hold);
    int kind, ch, acc, resp, nen;
    logic [5:0] exp_en, en;
    exp_t e;
    kind = (adr < 5'd16) ? 0 : (adr < 5'd18) ? 1 : 2;
    ch   = int'(adr) - 16;
    acc  = (kind == 0) ? 1 : (kind == 1) ? n_wait + 2 : -1;
    resp = (kind == 2) ? 1 : acc + 1;
    if (kind == 0)      exp_en = we ? 6'b010000 : 6'b100000;
    else if (kind == 1) exp_en = we ? (6'b000001 << ch) : (6'b000100 << ch);
    else                exp_en = 6'b000000;
    e.err  = (kind == 2);
    e.data = (!we && kind != 2) ? hd : last_rd;
    last_rd = e.data;
    exp_q.push_back(e);

    @(posedge clock); #1;
    strobe = 1'b1; we_i = we; adr_i = adr; wb_data_i = d;
    host_data_i = (acc == 1) ? hd : ~hd;
    if (kind == 1) begin
      if (we) fifo_write_wait[ch] = (n_wait > 0);
      else    fifo_read_wait[ch]  = (n_wait > 0);
    end
    @(posedge clock);
    nen = 0;
    for (int k = 1; k <= resp + hold; k++) begin
      @(negedge clock);
      en = {reg_read_en, reg_write_en, fifo_read_en, fifo_write_en};
      if (en != 6'b0) nen++;
      if (k == acc) begin
        check("enables", {122'b0, en}, {122'b0, exp_en});
        check("new_command", {127'b0, new_command},
              {127'b0, (kind == 0 && we && adr == 5'h03)});
        check("adr_o", {123'b0, adr_o}, {123'b0, adr});
        check("host_data_o", host_data_o, d);
      end
      if (k == resp)
        check("resp_latency", {127'b0, (kind == 2) ? error_o : ack_o}, 128'd1);
      host_data_i = (k + 1 == acc || k == acc) ? hd : ~hd;
      if (kind == 1 && k == n_wait + 1) begin
        fifo_write_wait = 2'b00; fifo_read_wait = 2'b00;
      end
    end
    check("enable_count", nen, (kind == 2) ? 0 : 1);
    @(posedge clock); #1;
    strobe = 1'b0; we_i = 1'b0; adr_i = '0;
    @(posedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {120'b0, ack_o, error_o, reg_read_en, reg_write_en,
                           fifo_read_en, fifo_write_en, new_command}, 128'd0);
    check({tag, "_adr_o"}, {123'b0, adr_o}, 128'd0);
    check({tag, "_host_data_o"}, host_data_o, 128'd0);
    check({tag, "_wb_data_o"}, wb_data_o, 128'd0);
  endtask

  initial begin
    reset = 1'b1; strobe = 1'b0; we_i = 1'b0; adr_i = '0; wb_data_i = '0;
    host_data_i = '0; fifo_read_wait = '0; fifo_write_wait = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    xfer(1'b1, 5'h03, 128'hA5,   128'h0,      0, 0);
    xfer(1'b0, 5'h01, 128'h0,    128'h1234,   0, 0);
    xfer(1'b1, 5'h05, 128'h77,   128'h0,      0, 0);
    xfer(1'b0, 5'h0F, 128'h0,    {64'hDEAD_BEEF_0000_1111, 64'h2222_3333_4444_5555}, 0, 0);
    xfer(1'b1, 5'h11, 128'hC0DE, 128'h0,      5, 0);
    xfer(1'b0, 5'h10, 128'h0,    128'hBEEF,   0, 0);
    xfer(1'b0, 5'h11, 128'h0,    128'hF00D,   2, 0);
    xfer(1'b0, 5'h1F, 128'h0,    128'h9999,   0, 3);
    xfer(1'b1, 5'h12, 128'h55,   128'h0,      0, 0);

    // Abort a stalled FIFO write with reset; no response may follow.
    @(posedge clock); #1;
    strobe = 1'b1; we_i = 1'b1; adr_i = 5'h11; wb_data_i = 128'hABC;
    fifo_write_wait = 2'b10;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; strobe = 1'b0; we_i = 1'b0; adr_i = '0; fifo_write_wait = 2'b00;
    last_rd = '0;
    @(negedge clock);
    check_all_zero("midreset");
    xfer(1'b0, 5'h02, 128'h0, 128'h4242, 0, 0);

`ifdef WB_SLAVE_MC_TIMEOUT_EN
    begin
      exp_t e;
      e.err = 1'b1; e.data = last_rd;
      exp_q.push_back(e);
      @(posedge clock); #1;
      strobe = 1'b1; we_i = 1'b0; adr_i = 5'h10; fifo_read_wait = 2'b01;
      @(posedge clock);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clock);
        check("timeout_no_pop", {126'b0, fifo_read_en}, 128'd0);
        check("timeout_error", {127'b0, error_o}, {127'b0, (k == 5)});
      end
      @(posedge clock); #1;
      strobe = 1'b0; adr_i = '0; fifo_read_wait = 2'b00;
      @(posedge clock);
    end
`endif

    repeat (4) @(posedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
